// File: rtl/corr_pkg.sv
// Shared definitions for the correlation search controller: scan state
// encoding, default geometry/width parameters and a sizing helper.
package corr_pkg;

  localparam int COORD_W_DEF   = 13;
  localparam int CORR_W_DEF    = 32;
  localparam int STEP_W_DEF    = 4;
  localparam int LED_DIV_W_DEF = 26;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Width of a counter that must reach timeoutCycles-1; at least one bit so
  // the counter still exists when the timeout is disabled.
  function automatic int timeoutCntWidth(input int timeoutCycles);
    return (timeoutCycles <= 2) ? 1 : $clog2(timeoutCycles);
  endfunction

endpackage

// File: rtl/corr_raster_gen.sv
// ROI raster coordinate generator. Latches the region bounds and step on
// load, then walks X fastest, Y slowest, with one extra bit of headroom so a
// step past the top of the coordinate range ends the scan instead of wrapping.
module corr_raster_gen
  import corr_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int STEP_W  = STEP_W_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iLoad,
  input  logic               iAdvance,
  input  logic [COORD_W-1:0] iXStart,
  input  logic [COORD_W-1:0] iXEnd,
  input  logic [COORD_W-1:0] iYStart,
  input  logic [COORD_W-1:0] iYEnd,
  input  logic [STEP_W-1:0]  iStep,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oLast
);

  localparam int EXT_W = COORD_W + 1;

  logic [COORD_W-1:0] xStartQ;
  logic [COORD_W-1:0] xEndQ;
  logic [COORD_W-1:0] yEndQ;
  logic [STEP_W-1:0]  stepQ;
  logic [EXT_W-1:0]   nx;
  logic [EXT_W-1:0]   ny;
  logic               xWrap;
  logic               yWrap;

  assign nx    = {1'b0, oX} + EXT_W'(stepQ);
  assign ny    = {1'b0, oY} + EXT_W'(stepQ);
  assign xWrap = nx > {1'b0, xEndQ};
  assign yWrap = ny > {1'b0, yEndQ};
  // The current point is the final one when both axes would step past their end.
  assign oLast = xWrap && yWrap;

  // Latch the ROI on load, otherwise step to the next raster point.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!iRST_N) begin
      xStartQ <= '0;
      xEndQ   <= '0;
      yEndQ   <= '0;
      stepQ   <= '0;
      oX      <= '0;
      oY      <= '0;
    end else if (iLoad) begin
      xStartQ <= iXStart;
      xEndQ   <= iXEnd;
      yEndQ   <= iYEnd;
      stepQ   <= iStep;
      oX      <= iXStart;
      oY      <= iYStart;
    end else if (iAdvance && !oLast) begin
      if (xWrap) begin
        oX <= xStartQ;
        oY <= ny[COORD_W-1:0];
      end else begin
        oX <= nx[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/corr_search_ctrl.sv
// Correlation search controller: issues ROI candidates to the correlator over
// a req/valid handshake, tracks the best (first-maximum) correlation and its
// coordinates, handles per-point timeout and abort, and drives a status LED.
module corr_search_ctrl
  import corr_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int CORR_W    = CORR_W_DEF,
  parameter int STEP_W    = STEP_W_DEF,
  parameter int LED_DIV_W = LED_DIV_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iFrameDone,
  input  logic               iAbort,
  input  logic [COORD_W-1:0] iXStart,
  input  logic [COORD_W-1:0] iXEnd,
  input  logic [COORD_W-1:0] iYStart,
  input  logic [COORD_W-1:0] iYEnd,
  input  logic [STEP_W-1:0]  iStep,
  output logic               oReq,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  input  logic               iCorrValid,
  input  logic [CORR_W-1:0]  iCorrValue,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic [CORR_W-1:0]  oBestCorr,
  output logic               oResultValid,
  output logic               oBusy,
  output logic               oTimeout,
  output logic               oCfgErr,
  output logic               oStatusLed
);

  localparam int              TO_W    = timeoutCntWidth(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);

  state_t               state;
  logic                 frameDoneQ;
  logic                 startQ;
  logic                 haveSample;
  logic [TO_W-1:0]      waitCnt;
  logic [LED_DIV_W-1:0] ledCnt;
  logic [COORD_W-1:0]   genX;
  logic [COORD_W-1:0]   genY;
  logic                 genLast;
  logic                 genLoad;
  logic                 genAdvance;
  logic                 cfgBad;

  assign cfgBad     = (iXStart > iXEnd) || (iYStart > iYEnd) || (iStep == '0);
  assign genLoad    = startQ && !iAbort && !cfgBad &&
                      ((state == ST_IDLE) || (state == ST_DONE));
  assign genAdvance = (state == ST_NEXT) && !iAbort;

  // Heartbeat while scanning, dark when idle, steady on when a result is held.
  assign oStatusLed = (state == ST_DONE) || (oBusy && ledCnt[LED_DIV_W-1]);

  corr_raster_gen #(
    .COORD_W (COORD_W),
    .STEP_W  (STEP_W)
  ) u_raster (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iLoad    (genLoad),
    .iAdvance (genAdvance),
    .iXStart  (iXStart),
    .iXEnd    (iXEnd),
    .iYStart  (iYStart),
    .iYEnd    (iYEnd),
    .iStep    (iStep),
    .oX       (genX),
    .oY       (genY),
    .oLast    (genLast)
  );

  // Registered rising-edge detect on iFrameDone produces a one-cycle start pulse.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frameDoneQ <= 1'b0;
      startQ     <= 1'b0;
    end else begin
      frameDoneQ <= iFrameDone;
      startQ     <= iFrameDone && !frameDoneQ;
    end
  end

  // Free-running divider for the busy heartbeat.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) ledCnt <= '0;
    else         ledCnt <= ledCnt + 1'b1;
  end

  // Scan FSM with handshake, max tracking, timeout and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= ST_IDLE;
      oReq         <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oXresult     <= '0;
      oYresult     <= '0;
      oBestCorr    <= '0;
      oResultValid <= 1'b0;
      oBusy        <= 1'b0;
      oTimeout     <= 1'b0;
      oCfgErr      <= 1'b0;
      haveSample   <= 1'b0;
      waitCnt      <= '0;
    end else if (iAbort) begin
      state        <= ST_IDLE;
      oReq         <= 1'b0;
      oBusy        <= 1'b0;
      oResultValid <= 1'b0;
      oXresult     <= '0;
      oYresult     <= '0;
      oBestCorr    <= '0;
      haveSample   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (startQ) begin
            oXresult     <= '0;
            oYresult     <= '0;
            oBestCorr    <= '0;
            oResultValid <= 1'b0;
            oTimeout     <= 1'b0;
            haveSample   <= 1'b0;
            if (cfgBad) begin
              oCfgErr <= 1'b1;
              oBusy   <= 1'b0;
              state   <= ST_DONE;
            end else begin
              oCfgErr <= 1'b0;
              oBusy   <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          oX      <= genX;
          oY      <= genY;
          oReq    <= 1'b1;
          waitCnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iCorrValid) begin
            // First sample loads unconditionally; later ones only if strictly greater.
            if (!haveSample || (iCorrValue > oBestCorr)) begin
              oBestCorr <= iCorrValue;
              oXresult  <= oX;
              oYresult  <= oY;
            end
            haveSample <= 1'b1;
            oReq       <= 1'b0;
            state      <= ST_NEXT;
          end else if (TO_EN && (waitCnt == TO_LAST)) begin
            oTimeout <= 1'b1;
            oReq     <= 1'b0;
            state    <= ST_NEXT;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (genLast) begin
            oBusy        <= 1'b0;
            oResultValid <= haveSample;
            state        <= ST_DONE;
          end else begin
            state <= ST_ISSUE;
          end
        end
        default: begin
          oReq  <= 1'b0;
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/corr_search_ctrl.md
Name: corr_search_ctrl

Overview:
Parametrised successor to the single-window correlation scan controller. It walks a programmable rectangular region of interest in raster order with a programmable step, and issues each (X,Y) candidate to the correlator over a req/valid handshake. It tracks the maximum correlation and its coordinates, and reports a stable result per frame. It sits between the frame-save logic and the correlator core; its outputs drive the overlay/readout logic and a board status LED.

Parameters:
COORD_W, 13, width of X/Y coordinates
CORR_W, 32, width of correlation value
STEP_W, 4, width of scan step input
LED_DIV_W, 26, heartbeat divider width; LED toggles on the divider MSB
TIMEOUT, 1024, max cycles waiting for iCorrValid per point; 0 disables

Ports:
iCLK  in  1  control clock (50 MHz)
iRST_N  in  1  asynchronous active-low reset
iFrameDone  in  1  level; rising edge requests a new scan
iAbort  in  1  synchronous abort of any scan
iXStart  in  COORD_W  ROI first X
iXEnd  in  COORD_W  ROI last X (inclusive bound)
iYStart  in  COORD_W  ROI first Y
iYEnd  in  COORD_W  ROI last Y (inclusive bound)
iStep  in  STEP_W  X and Y increment
oReq  out  1  candidate request to correlator
oX  out  COORD_W  candidate X, stable while oReq=1
oY  out  COORD_W  candidate Y, stable while oReq=1
iCorrValid  in  1  correlator result strobe
iCorrValue  in  CORR_W  correlation for current candidate
oXresult  out  COORD_W  X of best correlation
oYresult  out  COORD_W  Y of best correlation
oBestCorr  out  CORR_W  best correlation value
oResultValid  out  1  high in DONE with at least one accepted sample
oBusy  out  1  high in ISSUE/WAIT/NEXT
oTimeout  out  1  sticky: at least one point timed out this scan
oCfgErr  out  1  sticky: bad ROI/step at last start
oStatusLed  out  1  heartbeat

Behaviour:
- Reset (async, iRST_N=0): state IDLE; all outputs 0; edge-detect register 0; counters 0.
- Start = iFrameDone rising edge (registered edge detect, 1-cycle detection latency). Accepted only in IDLE or DONE; ignored while busy.
- On start: latch ROI and step into internal registers. Later input changes do not affect the scan. Clear best/valid/timeout/cfgerr.
- Config check: if iXStart>iXEnd, iYStart>iYEnd or iStep==0, go to DONE with oCfgErr=1 and oResultValid=0.
- States:
  - IDLE: waits for start.
  - ISSUE: load oX/oY, assert oReq; go to WAIT.
  - WAIT: hold oReq until iCorrValid, then go to NEXT and deassert oReq.
  - NEXT: advance coordinates; go to ISSUE, or to DONE after the last point.
  - DONE: result held until next start or iAbort.
- iCorrValid is ignored outside WAIT.
- Advance arithmetic in COORD_W+1 bits (no wrap): nx=x+step. If nx>xEnd then x=xStart and ny=y+step; if ny>yEnd the scan is finished. Points are visited only while ≤ end bound, so the end point is visited only if it is reachable from the start by whole steps.
- Max tracking: the first accepted sample loads best unconditionally, including a zero value. After that, update only on a strictly greater value, so the first maximum in raster order wins. Comparison is unsigned.
- Result latency: oResultValid rises 1 cycle after the final point's NEXT cycle (2 cycles after the last iCorrValid).
- Timeout: if TIMEOUT≠0 and WAIT has lasted TIMEOUT cycles without iCorrValid, skip the point (best unchanged), set oTimeout, and go to NEXT. iCorrValid in the same cycle as the timeout counts as valid.
- iAbort takes priority over all else: it goes to IDLE and clears oReq, oBusy and oResultValid. It also clears oXresult, oYresult and oBestCorr. iAbort in the same cycle as start goes to IDLE.
- oStatusLed: IDLE=0; busy = LED_DIV_W-bit free-running counter MSB; DONE=1 (steady).
- Single-point ROI (start==end on both axes) gives one request, then DONE.

Decomposition:
- Shared package corr_pkg: state encoding (IDLE, ISSUE, WAIT, NEXT, DONE), default COORD_W/CORR_W, TIMEOUT default.
- One natural sub-module: corr_raster_gen, holding the ROI coordinate generator with step and last-point detection. The FSM, max tracker, timeout and LED stay in the top module.

Test Plan:
- ROI X 0..3, Y 0..1, step 1, correlator returns value = 10*Y+X after 2 cycles -> 8 requests in raster order; result (3,1), best 13, oResultValid=1.
- ROI X 0..6, step 3, Y 0..0, values 5,9,9 -> requests X=0,3,6; result X=3 (tie keeps first); best 9.
- Correlator never responds, TIMEOUT=16, ROI 2x1 -> each point leaves WAIT after 16 cycles; DONE with oTimeout=1, oResultValid=0.
- iXStart=5, iXEnd=2 -> no oReq; DONE, oCfgErr=1, LED steady on.
- iAbort asserted mid-WAIT -> next cycle IDLE; oReq=0, oResultValid=0. A new iFrameDone rising edge restarts from the ROI origin.
- iFrameDone toggled while busy, and iCorrValid pulsed in IDLE -> both ignored; scan completes unchanged. Async reset mid-scan -> all outputs 0 immediately.
